// File: rtl/shifter_seq_n_if.sv
// Start/busy/done handshake and operand/result bus for the
// multi-cycle dual-channel shifter.
interface shifter_seq_n_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [AMT_W-1:0] Cantidad;
   logic [1:0]       Modo;
   logic [WIDTH-1:0] Res_A;
   logic [WIDTH-1:0] Res_B;
   logic             Ult_A;
   logic             Ult_B;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B, Cantidad, Modo,
      input  Res_A, Res_B, Ult_A, Ult_B, busy, done
   );

   modport slave (
      input  start, A, B, Cantidad, Modo,
      output Res_A, Res_B, Ult_A, Ult_B, busy, done
   );
endinterface

// File: rtl/shifter_seq_n.sv
// Multi-cycle dual-channel shifter: one bit position per clock,
// logical/arithmetic/rotate modes, last-bit-out flags.
module shifter_seq_n #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic          clk,
   input  logic          rst,
   shifter_seq_n_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       modo_q, modo_d;
   logic [WIDTH-1:0] wa_q, wa_d;
   logic [WIDTH-1:0] wb_q, wb_d;
   logic             fa_q, fa_d;
   logic             fb_q, fb_d;
   logic [WIDTH-1:0] res_a_q, res_a_d;
   logic [WIDTH-1:0] res_b_q, res_b_d;
   logic             ult_a_q, ult_a_d;
   logic             ult_b_q, ult_b_d;
   logic [WIDTH:0]   step_a;
   logic [WIDTH:0]   step_b;

   // Result packs the bit leaving the boundary above the new word.
   function automatic logic [WIDTH:0] shift_step(
      input logic [WIDTH-1:0] x,
      input logic [1:0]       m
   );
      logic [WIDTH:0] r;
      unique case (m)
         2'b00:   r = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
         2'b01:   r = {x[0], 1'b0, x[WIDTH-1:1]};
         2'b10:   r = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
         default: r = {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         modo_q  <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
         fa_q    <= 1'b0;
         fb_q    <= 1'b0;
         res_a_q <= '0;
         res_b_q <= '0;
         ult_a_q <= 1'b0;
         ult_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         modo_q  <= modo_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         res_a_q <= res_a_d;
         res_b_q <= res_b_d;
         ult_a_q <= ult_a_d;
         ult_b_q <= ult_b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      modo_d  = modo_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      res_a_d = res_a_q;
      res_b_d = res_b_q;
      ult_a_d = ult_a_q;
      ult_b_d = ult_b_q;
      step_a  = shift_step(wa_q, modo_q);
      step_b  = shift_step(wb_q, modo_q);
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               wa_d   = bus.A;
               wb_d   = bus.B;
               fa_d   = 1'b0;
               fb_d   = 1'b0;
               modo_d = bus.Modo;
               cnt_d  = bus.Cantidad;
               // Zero amount skips SHIFT and publishes operands as-is.
               if (bus.Cantidad == '0) begin
                  state_d = S_DONE;
                  res_a_d = bus.A;
                  res_b_d = bus.B;
                  ult_a_d = 1'b0;
                  ult_b_d = 1'b0;
               end else begin
                  state_d = S_SHIFT;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            wa_d  = step_a[WIDTH-1:0];
            wb_d  = step_b[WIDTH-1:0];
            fa_d  = step_a[WIDTH];
            fb_d  = step_b[WIDTH];
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = S_DONE;
               res_a_d = step_a[WIDTH-1:0];
               res_b_d = step_b[WIDTH-1:0];
               ult_a_d = step_a[WIDTH];
               ult_b_d = step_b[WIDTH];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state_q == S_SHIFT);
      bus.done  = (state_q == S_DONE);
      bus.Res_A = res_a_q;
      bus.Res_B = res_b_q;
      bus.Ult_A = ult_a_q;
      bus.Ult_B = ult_b_q;
   end

endmodule

// File: tb/tb_shifter_seq_n.sv
// Scoreboard bench for shifter_seq_n: stimulus pushes expected
// results, a negedge monitor pops them on every done pulse.
module tb_shifter_seq_n;

   typedef struct {
      logic [7:0] ra;
      logic [7:0] rb;
      logic       ua;
      logic       ub;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   shifter_seq_n_if #(.WIDTH(8), .AMT_W(3)) bus ();

   shifter_seq_n #(.WIDTH(8), .AMT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.busy && bus.done)
         chk("busy_and_done", 1, 0);
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("Res_A", {24'd0, bus.Res_A}, {24'd0, e.ra});
            chk("Res_B", {24'd0, bus.Res_B}, {24'd0, e.rb});
            chk("Ult_A", {31'd0, bus.Ult_A}, {31'd0, e.ua});
            chk("Ult_B", {31'd0, bus.Ult_B}, {31'd0, e.ub});
         end
      end
   end

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] n, input logic [1:0] m);
      bus.start    = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.Cantidad = n;
      bus.Modo     = m;
   endtask

   // Checks busy/done timing for each cycle c+1..c+n+1; poke>0
   // raises a stray start in cycle c+poke, which must be ignored.
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] n, input logic [1:0] m,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic ua, input logic ub,
                        input int poke);
      exp_t e;
      @(negedge clk);
      drive(a, b, n, m);
      e.ra = ea; e.rb = eb; e.ua = ua; e.ub = ub;
      sb.push_back(e);
      for (int k = 1; k <= int'(n) + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.start = 1'b0;
            bus.A     = ~a;
            bus.B     = ~b;
            bus.Modo  = ~m;
         end
         if (poke > 0 && k == poke) drive(8'h33, 8'hCC, 3'd1, 2'b11);
         if (poke > 0 && k == poke + 1) bus.start = 1'b0;
         chk("busy_t", {31'd0, bus.busy}, {31'd0, k <= int'(n)});
         chk("done_t", {31'd0, bus.done}, {31'd0, k == int'(n) + 1});
      end
      bus.start = 1'b0;
   endtask

   initial begin
      exp_t e;
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      bus.Cantidad = '0;
      bus.Modo     = '0;
      @(negedge clk);
      chk("rst_Res_A", {24'd0, bus.Res_A}, 0);
      chk("rst_Res_B", {24'd0, bus.Res_B}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_done", {31'd0, bus.done}, 0);
      rst = 1'b0;

      issue(8'h96, 8'h96, 3'd3, 2'b00, 8'hB0, 8'hB0, 0, 0, 0);
      @(negedge clk);
      chk("hold_Res_A", {24'd0, bus.Res_A}, 32'hB0);
      issue(8'h96, 8'h80, 3'd2, 2'b10, 8'hE5, 8'hE0, 1, 0, 0);
      issue(8'h96, 8'h80, 3'd2, 2'b01, 8'h25, 8'h20, 1, 0, 0);
      issue(8'h96, 8'h01, 3'd3, 2'b11, 8'hB4, 8'h08, 0, 0, 0);
      issue(8'h81, 8'h81, 3'd7, 2'b11, 8'hC0, 8'hC0, 0, 0, 0);
      issue(8'h80, 8'h80, 3'd7, 2'b01, 8'h01, 8'h01, 0, 0, 0);
      issue(8'h80, 8'h7F, 3'd7, 2'b10, 8'hFF, 8'h00, 0, 1, 0);
      issue(8'hFF, 8'h01, 3'd7, 2'b00, 8'h80, 8'h80, 1, 0, 0);
      for (int md = 0; md < 4; md++)
         issue(8'h5A, 8'hA5, 3'd0, 2'(md), 8'h5A, 8'hA5, 0, 0, 0);
      issue(8'h0F, 8'hF0, 3'd4, 2'b00, 8'hF0, 8'h00, 0, 1, 2);

      // Back-to-back: start held during the DONE cycle.
      @(negedge clk);
      drive(8'h96, 8'h96, 3'd2, 2'b01);
      e.ra = 8'h25; e.rb = 8'h25; e.ua = 1; e.ub = 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_done", {31'd0, bus.done}, 1);
      drive(8'h03, 8'hC0, 3'd1, 2'b11);
      e.ra = 8'h06; e.rb = 8'h81; e.ua = 0; e.ub = 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy", {31'd0, bus.busy}, 1);
      @(negedge clk);
      chk("b2b_done2", {31'd0, bus.done}, 1);

      // Reset mid-SHIFT aborts with no done pulse.
      @(negedge clk);
      drive(8'hFF, 8'hFF, 3'd4, 2'b00);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("abort_busy_pre", {31'd0, bus.busy}, 1);
      rst = 1'b1;
      #1;
      chk("abort_Res_A", {24'd0, bus.Res_A}, 0);
      chk("abort_Res_B", {24'd0, bus.Res_B}, 0);
      chk("abort_Ult", {30'd0, bus.Ult_A, bus.Ult_B}, 0);
      chk("abort_busy", {31'd0, bus.busy}, 0);
      chk("abort_done", {31'd0, bus.done}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, bus.done}, 0);
      end
      issue(8'h96, 8'h96, 3'd3, 2'b00, 8'hB0, 8'hB0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shifter_seq_n.md
Name: shifter_seq_n

Overview:
Parametrised, multi-cycle dual-channel shifter unit for the ALU datapath.
Shifts operands A and B together, one bit position per clock, by a run-time amount, in one of four modes.
Uses a start/busy/done handshake so the ALU controller can sequence it.
Replaces fixed-width, 2-bit-amount, logical-only combinational shifting with a general WIDTH/AMT_W unit that adds arithmetic and rotate modes and shifted-out bit flags.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
AMT_W, 3, width of shift amount Cantidad; maximum shift = 2^AMT_W-1 (may exceed WIDTH)

Ports:
clk  input  1  system clock, all state rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
A  input  WIDTH  channel A operand, captured on accepted start
B  input  WIDTH  channel B operand, captured on accepted start
Cantidad  input  AMT_W  shift amount, captured on accepted start
Modo  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left; captured on accepted start
Res_A  output  WIDTH  channel A result, registered
Res_B  output  WIDTH  channel B result, registered
Ult_A  output  1  last bit shifted out of / rotated across channel A
Ult_B  output  1  same for channel B
busy  output  1  high while shifting
done  output  1  one-cycle pulse, results valid

Behaviour:
- Reset, async, takes effect immediately: state=IDLE; Res_A, Res_B, Ult_A, Ult_B, busy, done = 0; internal working registers and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- Start acceptance: in IDLE or DONE, start=1 at an edge captures A, B, Cantidad and Modo into the working registers, and clears the working flags to 0.
  - Cantidad=0: next state is DONE.
  - Cantidad>0: next state is SHIFT, with cnt=Cantidad.
- SHIFT, each edge:
  - Both working registers move one position per Modo.
  - The working flag for each channel takes the bit leaving the boundary: MSB for left/rotate, LSB for right modes.
  - cnt decrements by 1; when cnt==1 at the edge, next state is DONE.
- Per-step mode rules:
  - Logical left fills LSB with 0.
  - Logical right fills MSB with 0.
  - Arithmetic right replicates the MSB.
  - Rotate left moves the MSB into the LSB.
- Amounts >= WIDTH fall out naturally, one step per cycle:
  - Logical modes give all zeros.
  - Arithmetic right gives all sign bits.
  - Rotate wraps modulo WIDTH.
- Entering DONE, at the same edge: Res_A/Res_B/Ult_A/Ult_B are loaded from the working values.
- Outputs hold until the next DONE entry or reset.
- DONE lasts exactly one cycle with done=1, then returns to IDLE, unless start=1 in that cycle (back-to-back accept).
- busy=1 exactly when state=SHIFT; done=1 exactly when state=DONE; busy and done are never both 1.
- Latency: start high in cycle c → done high in cycle c+N+1 for N=Cantidad (N=0 → c+1).
- start while busy=1 is ignored; it does not restart or alter the operation.
- Inputs A, B, Cantidad and Modo may change freely after acceptance without effect.
- Reset mid-SHIFT aborts the operation; no done pulse occurs; outputs read 0.
- Cantidad=0 gives Res equal to the operand and Ult=0 in every mode.

Test Plan:
- WIDTH=8, A=0x96, B=0x96, Modo=00, Cantidad=3, start in cycle c → busy in c+1..c+3; done only in c+4; Res_A=Res_B=0xB0, Ult=0.
- A=0x96, B=0x80, Modo=10, Cantidad=2 → Res_A=0xE5, Ult_A=1; Res_B=0xE0, Ult_B=0. Repeat with Modo=01 → Res_A=0x25, Res_B=0x20.
- A=0x96, Modo=11, Cantidad=3 → Res_A=0xB4, Ult_A=0. Then A=0x81, Cantidad=7 → Res_A=0xC0 (rotate left 7 = rotate right 1), Ult_A=0.
- A=0x80, Cantidad=7: Modo=01 → 0x01; Modo=10 → 0xFF. Cantidad=0 with A=0x5A, any mode → done in c+1, Res_A=0x5A, Ult_A=0.
- Start at c with Cantidad=4, second start with different operands at c+2 → ignored; single done at c+5 with the first result. Start held high during the DONE cycle → new operation accepted back-to-back, busy in the next cycle.
- Assert rst during SHIFT → all outputs 0 immediately, state IDLE, no done pulse. A fresh start after reset completes normally.
